// File: rtl/cmplx_pkg.sv
// Shared constants and packing helpers for the pipelined complex multiplier.
// Packed complex words carry the real part in the upper half and the imaginary part in the lower half.
package cmplx_pkg;

   localparam int unsigned CMULT_NBITS      = 16;
   localparam int unsigned CMULT_NBITSCOEFF = 16;
   localparam int unsigned CMULT_NOUT       = 16;
   localparam int unsigned CMULT_LAT        = 3;

   // The helpers work on a fixed wide container, so any component width up to CMULT_MAXW fits.
   localparam int unsigned CMULT_MAXW = 64;
   localparam int unsigned CMULT_VW   = 2 * CMULT_MAXW;

   function automatic logic [CMULT_MAXW-1:0] cx_mask(input int unsigned w);
      if (w >= CMULT_MAXW)
         return '1;
      return (CMULT_MAXW'(1) << w) - CMULT_MAXW'(1);
   endfunction

   function automatic logic [CMULT_MAXW-1:0] cx_re(input logic [CMULT_VW-1:0] v, input int unsigned w);
      logic [CMULT_VW-1:0] t;
      t = v >> w;
      return t[CMULT_MAXW-1:0] & cx_mask(w);
   endfunction

   function automatic logic [CMULT_MAXW-1:0] cx_im(input logic [CMULT_VW-1:0] v, input int unsigned w);
      return v[CMULT_MAXW-1:0] & cx_mask(w);
   endfunction

   function automatic logic [CMULT_VW-1:0] cx_pack(input logic [CMULT_MAXW-1:0] re,
                                                  input logic [CMULT_MAXW-1:0] im,
                                                  input int unsigned w);
      logic [CMULT_VW-1:0] t;
      t = {{CMULT_MAXW{1'b0}}, re & cx_mask(w)} << w;
      return t | {{CMULT_MAXW{1'b0}}, im & cx_mask(w)};
   endfunction

endpackage

// File: rtl/cmplx_scale.sv
// Scales a full-precision sum down to NOUT bits and flags out-of-range results.
// CMULT_ROUND_SAT_EN selects round-half-up with saturation; otherwise floor with wrap-around.
module cmplx_scale
   import cmplx_pkg::*;
#(
   parameter int unsigned NIN   = 33,
   parameter int unsigned NOUT  = 16,
   parameter int unsigned SHIFT = 15
) (
   input  logic signed [NIN-1:0]  i_sum,
   output logic signed [NOUT-1:0] o_val,
   output logic                   o_ovf
);

   // One guard bit so the rounding constant can never overflow the sum.
   localparam int unsigned NW = NIN + 1;

   logic signed [NW-1:0] w_ext;
   logic signed [NW-1:0] w_shf;
   logic [NW-NOUT:0]     w_top;

   assign w_ext = NW'(i_sum);

`ifdef CMULT_ROUND_SAT_EN
   localparam logic [NW-1:0]          RND_U = (NW'(1) << SHIFT) >> 1;
   localparam logic signed [NOUT-1:0] VMAX  = {1'b0, {(NOUT-1){1'b1}}};
   localparam logic signed [NOUT-1:0] VMIN  = {1'b1, {(NOUT-1){1'b0}}};

   logic signed [NW-1:0] w_bias;

   assign w_bias = w_ext + $signed(RND_U);
   assign w_shf  = w_bias >>> SHIFT;
`else
   assign w_shf  = w_ext >>> SHIFT;
`endif

   // In range exactly when every bit above the output sign bit repeats it.
   assign w_top = w_shf[NW-1:NOUT-1];
   assign o_ovf = ~((&w_top) | ~(|w_top));

`ifdef CMULT_ROUND_SAT_EN
   assign o_val = o_ovf ? (w_shf[NW-1] ? VMIN : VMAX) : w_shf[NOUT-1:0];
`else
   assign o_val = w_shf[NOUT-1:0];
`endif

endmodule

// File: rtl/cmplx_mult_pipe.sv
// Three-stage complex multiplier (sample x coeff or x conj(coeff)) with valid/ready backpressure.
// Output scaling mode is selected by CMULT_ROUND_SAT_EN (see cmplx_scale).
module cmplx_mult_pipe
   import cmplx_pkg::*;
#(
   parameter int unsigned NBITS      = CMULT_NBITS,
   parameter int unsigned NBITSCOEFF = CMULT_NBITSCOEFF,
   parameter int unsigned NOUT       = CMULT_NOUT,
   parameter int unsigned SHIFT      = NBITSCOEFF - 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [2*NBITS-1:0]        muestra,
   input  logic [2*NBITSCOEFF-1:0]   coeff,
   input  logic                      conj,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [2*NOUT-1:0]         result,
   output logic                      ovf
);

   localparam int unsigned NP = NBITS + NBITSCOEFF;
   localparam int unsigned NS = NP + 1;

   logic signed [NBITS-1:0]      w_m_r, w_m_i;
   logic signed [NBITSCOEFF-1:0] w_c_r, w_c_i;
   logic                         w_adv;

   logic                         r_v1, r_cj1;
   logic signed [NBITS-1:0]      r_m_r, r_m_i;
   logic signed [NBITSCOEFF-1:0] r_c_r, r_c_i;

   logic                         r_v2, r_cj2;
   logic signed [NP-1:0]         r_rr, r_ii, r_ri, r_ir;

   logic                         r_v3, r_ovf;
   logic signed [NOUT-1:0]       r_re, r_im;

   logic signed [NS-1:0]         w_sum_re, w_sum_im;
   logic signed [NOUT-1:0]       w_re, w_im;
   logic                         w_ovf_re, w_ovf_im;

   assign w_m_r = NBITS'(cx_re(CMULT_VW'(muestra), NBITS));
   assign w_m_i = NBITS'(cx_im(CMULT_VW'(muestra), NBITS));
   assign w_c_r = NBITSCOEFF'(cx_re(CMULT_VW'(coeff), NBITSCOEFF));
   assign w_c_i = NBITSCOEFF'(cx_im(CMULT_VW'(coeff), NBITSCOEFF));

   // A single enable moves the whole pipe, so a stalled output freezes every stage.
   assign w_adv    = ~r_v3 | out_ready;
   assign in_ready = w_adv & ~rst;

   always_comb begin
      w_sum_re = '0;
      w_sum_im = '0;
      if (r_cj2) begin
         w_sum_re = NS'(r_rr) + NS'(r_ii);
         w_sum_im = NS'(r_ir) - NS'(r_ri);
      end else begin
         w_sum_re = NS'(r_rr) - NS'(r_ii);
         w_sum_im = NS'(r_ri) + NS'(r_ir);
      end
   end

   cmplx_scale #(.NIN(NS), .NOUT(NOUT), .SHIFT(SHIFT)) u_scale_re (
      .i_sum (w_sum_re),
      .o_val (w_re),
      .o_ovf (w_ovf_re)
   );

   cmplx_scale #(.NIN(NS), .NOUT(NOUT), .SHIFT(SHIFT)) u_scale_im (
      .i_sum (w_sum_im),
      .o_val (w_im),
      .o_ovf (w_ovf_im)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1  <= 1'b0;
         r_cj1 <= 1'b0;
         r_m_r <= '0;
         r_m_i <= '0;
         r_c_r <= '0;
         r_c_i <= '0;
         r_v2  <= 1'b0;
         r_cj2 <= 1'b0;
         r_rr  <= '0;
         r_ii  <= '0;
         r_ri  <= '0;
         r_ir  <= '0;
         r_v3  <= 1'b0;
         r_re  <= '0;
         r_im  <= '0;
         r_ovf <= 1'b0;
      end else if (w_adv) begin
         r_v1 <= in_valid;
         if (in_valid) begin
            r_m_r <= w_m_r;
            r_m_i <= w_m_i;
            r_c_r <= w_c_r;
            r_c_i <= w_c_i;
            r_cj1 <= conj;
         end
         r_v2 <= r_v1;
         if (r_v1) begin
            r_rr  <= NP'(r_m_r) * NP'(r_c_r);
            r_ii  <= NP'(r_m_i) * NP'(r_c_i);
            r_ri  <= NP'(r_m_r) * NP'(r_c_i);
            r_ir  <= NP'(r_m_i) * NP'(r_c_r);
            r_cj2 <= r_cj1;
         end
         r_v3 <= r_v2;
         if (r_v2) begin
            r_re <= w_re;
            r_im <= w_im;
            if (w_ovf_re | w_ovf_im)
               r_ovf <= 1'b1;
         end
      end
   end

   assign out_valid = r_v3;
   assign ovf       = r_ovf;
   assign result    = (2*NOUT)'(cx_pack(CMULT_MAXW'(r_re), CMULT_MAXW'(r_im), NOUT));

endmodule

// File: tb/tb_cmplx_mult_pipe.sv
// Scoreboard bench for cmplx_mult_pipe: directed vectors, backpressure, random traffic, mid-stream reset.
// Expected values follow CMULT_ROUND_SAT_EN the same way the design does.
module tb_cmplx_mult_pipe;
   import cmplx_pkg::*;

   localparam int SHIFT = 15;
   localparam longint VMAX = 32767;
   localparam longint VMIN = -32768;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, conj, out_valid, out_ready, ovf;
   logic [31:0] muestra, coeff, result;

   typedef struct {
      logic [31:0] res;
      bit          ov;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   stall_req = 0;
   bit   rand_rdy  = 1'b0;

   cmplx_mult_pipe #(.NBITS(16), .NBITSCOEFF(16), .NOUT(16), .SHIFT(SHIFT)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .muestra   (muestra),
      .coeff     (coeff),
      .conj      (conj),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] cx(input int re, input int im);
      return {re[15:0], im[15:0]};
   endfunction

   function automatic void scale_ref(input longint s, output logic [15:0] v, output bit o);
      longint t;
`ifdef CMULT_ROUND_SAT_EN
      t = (s + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
      o = 1'b0;
      if (t > VMAX) begin
         t = VMAX;
         o = 1'b1;
      end else if (t < VMIN) begin
         t = VMIN;
         o = 1'b1;
      end
`else
      t = s >>> SHIFT;
      o = (t > VMAX) || (t < VMIN);
`endif
      v = t[15:0];
   endfunction

   function automatic void model(input logic [31:0] m, input logic [31:0] c, input bit cj,
                                 output logic [31:0] r, output bit o);
      longint mr, mi, cr, ci, sre, sim;
      logic [15:0] vr, vi;
      bit ov_r, ov_i;
      mr = longint'($signed(m[31:16]));
      mi = longint'($signed(m[15:0]));
      cr = longint'($signed(c[31:16]));
      ci = longint'($signed(c[15:0]));
      if (cj) begin
         sre = mr * cr + mi * ci;
         sim = mi * cr - mr * ci;
      end else begin
         sre = mr * cr - mi * ci;
         sim = mr * ci + mi * cr;
      end
      scale_ref(sre, vr, ov_r);
      scale_ref(sim, vi, ov_i);
      r = {vr, vi};
      o = ov_r | ov_i;
   endfunction

   // Presents one beat and records its expected output once the handshake completes.
   task automatic issue(input logic [31:0] m, input logic [31:0] c, input bit cj,
                        input logic [31:0] er, input bit eo);
      bit acc = 1'b0;
      int n   = 0;
      exp_t e;
      in_valid = 1'b1;
      muestra  = m;
      coeff    = c;
      conj     = cj;
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (acc) begin
         e.res = er;
         e.ov  = eo;
         q.push_back(e);
      end else begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got no accept expected accept within 100 cycles");
      end
   endtask

   task automatic send(input logic [31:0] m, input logic [31:0] c, input bit cj);
      logic [31:0] er;
      bit eo;
      model(m, c, cj, er, eo);
      issue(m, c, cj, er, eo);
   endtask

   task automatic drain();
      int n = 0;
      in_valid = 1'b0;
      while (q.size() != 0 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_empty", q.size(), 0);
   endtask

   // Downstream ready: steady, random, or a 4-cycle forced stall on request.
   initial begin
      int seen = 0;
      int left = 0;
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (stall_req != seen) begin
            seen = stall_req;
            left = 4;
         end
         if (left > 0) begin
            out_ready = 1'b0;
            left--;
         end else begin
            out_ready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
         end
      end
   end

   // Monitor: pops on every output handshake and checks hold-while-stalled.
   initial begin
      bit          sticky  = 1'b0;
      bit          stalled = 1'b0;
      logic [31:0] held    = '0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (rst) begin
            q.delete();
            sticky  = 1'b0;
            stalled = 1'b0;
         end else begin
            if (stalled && out_valid)
               chk("hold_result", result, held);
            stalled = 1'b0;
            if (out_valid && !out_ready) begin
               chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
               held    = result;
               stalled = 1'b1;
            end
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_out: got result %h expected no output", result);
               end else begin
                  e = q.pop_front();
                  sticky = sticky | e.ov;
                  chk("result", result, e.res);
                  chk("ovf", {31'b0, ovf}, {31'b0, sticky});
               end
            end
         end
      end
   end

   initial begin
      int cnt;
      logic [31:0] er;
      bit eo;
      rst      = 1'b1;
      in_valid = 1'b0;
      muestra  = '0;
      coeff    = '0;
      conj     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready",  {31'b0, in_ready},  32'd0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_result",    result,             32'd0);
      chk("rst_ovf",       {31'b0, ovf},       32'd0);
      rst = 1'b0;

      issue(cx(1000, 2000), cx(16384, 0), 1'b0, cx(500, 1000), 1'b0);
      issue(cx(1000, 2000), cx(0, 16384), 1'b1, cx(1000, -500), 1'b0);
      issue(cx(1000, 2000), cx(0, 16384), 1'b0, cx(-1000, 500), 1'b0);
`ifdef CMULT_ROUND_SAT_EN
      issue(cx(1, 0),      cx(16384, 0),  1'b0, cx(1, 0),     1'b0);
      issue(cx(-1, 0),     cx(16384, 0),  1'b0, cx(0, 0),     1'b0);
      issue(cx(-32768, 0), cx(-32768, 0), 1'b0, cx(32767, 0), 1'b1);
`else
      issue(cx(1, 0),      cx(16384, 0),  1'b0, cx(0, 0),      1'b0);
      issue(cx(-1, 0),     cx(16384, 0),  1'b0, cx(-1, 0),     1'b0);
      issue(cx(-32768, 0), cx(-32768, 0), 1'b0, cx(-32768, 0), 1'b1);
`endif
      // Benign beats after the overflow: ovf must remain set.
      send(cx(100, -200), cx(8192, 8192), 1'b0);
      send(cx(-300, 50),  cx(-4096, 12000), 1'b1);
      drain();

      for (int i = 0; i < 10; i++) begin
         send(cx(i * 1000 - 4000, 3000 - i * 700), cx(12000 - i * 2000, i * 1500 - 6000), i[0]);
         if (i == 3)
            stall_req++;
      end
      drain();

      rand_rdy = 1'b1;
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         if ($urandom_range(0, 9) == 0)
            send(cx(-32768, $urandom_range(0, 1) ? -32768 : 32767), cx(-32768, -32768), 1'($urandom_range(0, 1)));
         else
            send($urandom, $urandom, 1'($urandom_range(0, 1)));
      end
      rand_rdy = 1'b0;
      drain();

      send(cx(1234, -5678), cx(20000, -3000), 1'b0);
      send(cx(-32768, 0),   cx(-32768, 0),    1'b0);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_mid_in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("post_rst_result",    result,             32'd0);
      chk("post_rst_ovf",       {31'b0, ovf},       32'd0);

      model(cx(300, -700), cx(16384, 16384), 1'b0, er, eo);
      in_valid = 1'b1;
      muestra  = cx(300, -700);
      coeff    = cx(16384, 16384);
      conj     = 1'b0;
      begin
         exp_t e;
         e.res = er;
         e.ov  = eo;
         q.push_back(e);
      end
      cnt = 0;
      while (cnt < 20) begin
         @(posedge clk);
         cnt++;
         #1;
         in_valid = 1'b0;
         if (out_valid)
            break;
      end
      chk("latency", cnt, CMULT_LAT);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
